fanout_fork_ctrl: RTL and testbench
===================================

# fanout_fork_ctrl

Eager-fork controller for one ready/valid stream broadcast to up to N_OUT consumers on the onyx interconnect. It holds one word and presents it to every enabled branch. It tracks which branches have already accepted the word, so slow branches do not block fast ones. It retires the word once every enabled branch has taken it. It sits between a primitive's output port and the fanout wires, and replaces the purely combinational all-ready AND with sequenced per-branch acceptance.

## Interface
- N_OUT, 7, number of fanout branches (1..16)
- W, 16, data width in bits
- CLK  in  1  clock; all state on rising edge
- ASYNCRESET  in  1  reset, asynchronous and active-high
- cfg_en  in  N_OUT  branch enable mask, sampled when a word is loaded
- flush  in  1  synchronous drop of the held word and all per-branch state
- in_data  in  W  upstream data
- in_valid  in  1  upstream valid
- in_ready  out  1  upstream ready
- out_data  out  W  held word, common to all branches
- out_valid  out  N_OUT  per-branch valid
- out_ready  in  N_OUT  per-branch ready
- busy  out  1  a word is held (hold_valid)
- stall_count  out  16  saturating count of stalled cycles (see Configuration)

## Operation
- State:
  - hold_valid, hold_data[W]
  - en_q[N_OUT]: mask latched at load
  - served[N_OUT]: branch already accepted the current word
- out_valid[i] = hold_valid & en_q[i] & ~served[i]; out_data = hold_data.
- Branch i accepts in a cycle where out_valid[i] & out_ready[i]. At the next edge, served[i] is set.
- done = hold_valid & AND over i of (~en_q[i] | served[i] | out_ready[i]).
- in_ready = ~flush & (~hold_valid | done).
- Load happens when in_valid & in_ready. It sets hold_valid, captures hold_data, sets en_q = cfg_en and clears served.
- If done and there is no load: hold_valid clears and served clears.
- Zero mask: if cfg_en == 0 at load, the word is held one cycle with no out_valid asserted, then retires (done = 1). Net effect is a sink at 1 word/cycle.
- flush:
  - Next edge: hold_valid = 0 and served = 0.
  - No load occurs in the flush cycle.
  - Acceptances in the flush cycle are discarded.
- A change on cfg_en while a word is held does not affect that word.
- No state machine beyond hold_valid: EMPTY (hold_valid = 0) and HELD (hold_valid = 1).
  - EMPTY goes to HELD on a load.
  - HELD stays HELD on done with a load.
  - HELD goes to EMPTY on done without a load, or on flush.

## Timing
- Reset values: hold_valid 0, hold_data 0, en_q 0, served 0, out_valid 0, in_ready 1, busy 0, stall_count 0.
- Latency: in_data accepted at edge k appears on out_data/out_valid in cycle k+1.
- Throughput: 1 word/cycle when all enabled branches are ready every cycle. in_ready is combinational from out_ready through done. There is no combinational path from in_valid to out_valid.
- A branch that accepted earlier never sees out_valid again for the same word. Each enabled branch sees exactly one handshake per word.
- When the last outstanding branch accepts while in_valid = 1, the next word loads in the same edge. That branch sees a new out_valid in the next cycle with no bubble.
- ASYNCRESET mid-word: the word is lost. Outputs go to reset values immediately, without waiting for a clock edge.

## Configuration
- FANOUT_STALL_CNT_EN defined:
  - stall_count increments at each edge where hold_valid & ~done & ~flush.
  - It saturates at 16'hFFFF.
  - It is cleared by ASYNCRESET only.
- FANOUT_STALL_CNT_EN undefined: stall_count is tied to 0 and no counter flops exist.

## Test plan
- N_OUT=3, cfg_en=3'b111, all out_ready=1, stream 0x0001..0x0004 on back-to-back cycles -> each branch sees four handshakes, 0x0001..0x0004 in order, one per cycle. in_ready stays 1 and busy=1 from the cycle after the first load.
- cfg_en=3'b111, word 0xA5A5; branch0 ready in cycle 1, branch2 in cycle 2, branch1 in cycle 4 -> out_valid goes 3'b111, 3'b110, 3'b010, 3'b010, then 0. in_ready=1 only in cycle 4. With the macro defined, stall_count=3.
- cfg_en=3'b101 with out_ready[1]=0 permanently, stream 0x0010,0x0011 -> out_valid[1] is never asserted and both words retire at 1/cycle.
- cfg_en=0, in_valid=1 for 5 cycles -> 5 words accepted, out_valid stays 0, in_ready stays 1.
- Word 0x1234 held with branch0 served; assert flush with in_valid=1 -> in_ready=0 in that cycle. Next cycle busy=0 and out_valid=0; the following load presents the new word to all enabled branches.
- Assert ASYNCRESET between edges while busy=1 -> busy, out_valid and stall_count read 0 before the next CLK edge.

Source files
------------

// File: rtl/fanout_fork_ctrl.sv
// Eager-fork controller: holds one word and broadcasts it to every enabled branch,
// tracking per-branch acceptance. Optional stall counter under FANOUT_STALL_CNT_EN.
module fanout_fork_ctrl #(
    parameter int unsigned N_OUT = 7,
    parameter int unsigned W     = 16
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [N_OUT-1:0] cfg_en,
    input  logic             flush,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic             busy,
    output logic [15:0]      stall_count
);

    localparam int unsigned CW = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [W-1:0]     hold_data;
    logic [W-1:0]     data_d;
    logic [N_OUT-1:0] en_q;
    logic [N_OUT-1:0] en_d;
    logic [N_OUT-1:0] served_q;
    logic [N_OUT-1:0] served_d;
    logic             hold_valid;
    logic             done;
    logic             load;

    assign hold_valid = (state_q == HELD);
    assign out_valid  = {N_OUT{hold_valid}} & en_q & ~served_q;
    assign out_data   = hold_data;
    assign busy       = hold_valid;

    // Word retires once every enabled branch has taken it or is taking it now.
    assign done     = hold_valid & (&(~en_q | served_q | out_ready));
    assign in_ready = ~flush & (~hold_valid | done);
    assign load     = in_valid & in_ready;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q   <= EMPTY;
            hold_data <= '0;
            en_q      <= '0;
            served_q  <= '0;
        end else begin
            state_q   <= state_d;
            hold_data <= data_d;
            en_q      <= en_d;
            served_q  <= served_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        data_d   = hold_data;
        en_d     = en_q;
        if (flush) begin
            state_d  = EMPTY;
            served_d = '0;
        end else if (load) begin
            state_d  = HELD;
            served_d = '0;
            data_d   = in_data;
            en_d     = cfg_en;
        end else if (done) begin
            state_d  = EMPTY;
            served_d = '0;
        end else begin
            served_d = served_q | (out_valid & out_ready);
        end
    end

`ifdef FANOUT_STALL_CNT_EN
    logic [CW-1:0] stall_q;

    // Saturating count of cycles where a held word could not retire.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            stall_q <= '0;
        end else if (hold_valid && !done && !flush && (stall_q != {CW{1'b1}})) begin
            stall_q <= stall_q + CW'(1);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = CW'(0);
`endif

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Self-checking bench for fanout_fork_ctrl (N_OUT=3): per-branch scoreboard of
// expected words plus directed cycle-level checks of valid/ready/busy/stall.
module tb_fanout_fork_ctrl;

    localparam int unsigned N = 3;
    localparam int unsigned DW = 16;
`ifdef FANOUT_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  cfg_en;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic          busy;
    logic [15:0]   stall_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q [N][$];
    int            hs_cnt [N];
    logic          obs_ready;
    logic [N-1:0]  obs_valid;
    logic          obs_busy;
    logic [N-1:0]  valid_seen;

    fanout_fork_ctrl #(.N_OUT(N), .W(DW)) dut (
        .CLK         (clk),
        .ASYNCRESET  (rst),
        .cfg_en      (cfg_en),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < int'(N); i++) exp_q[i].delete();
    endtask

    // One clock cycle: drive inputs, observe combinational outputs, update scoreboard.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [N-1:0] en,
                        input logic [N-1:0] rdy, input logic fl);
        logic [DW-1:0] e;
        in_valid  = iv;
        in_data   = d;
        cfg_en    = en;
        out_ready = rdy;
        flush     = fl;
        #1;
        obs_ready  = in_ready;
        obs_valid  = out_valid;
        obs_busy   = busy;
        valid_seen = valid_seen | out_valid;
        for (int i = 0; i < int'(N); i++) begin
            if (out_valid[i] && out_ready[i] && !fl) begin
                check($sformatf("sb_avail[%0d]", i), 32'(exp_q[i].size() > 0), 32'd1);
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                    check($sformatf("data[%0d]", i), 32'(out_data), 32'(e));
                end
                hs_cnt[i]++;
            end
        end
        if (fl) clear_sb();
        if (iv && in_ready) begin
            for (int i = 0; i < int'(N); i++)
                if (en[i]) exp_q[i].push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '1, '0, 1'b0);
    endtask

    initial begin
        logic [15:0] exp_stall;
        exp_stall = '0;
        for (int i = 0; i < int'(N); i++) hs_cnt[i] = 0;
        valid_seen = '0;
        rst = 1'b1; cfg_en = '0; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back stream, all branches ready.
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, DW'(k), 3'b111, 3'b111, 1'b0);
            check("t1_in_ready", 32'(obs_ready), 32'd1);
            check("t1_valid", 32'(obs_valid), (k == 1) ? 32'd0 : 32'd7);
            check("t1_busy", 32'(obs_busy), (k == 1) ? 32'd0 : 32'd1);
        end
        step(1'b0, '0, 3'b111, 3'b111, 1'b0);
        check("t1_valid_last", 32'(obs_valid), 32'd7);
        idle();
        check("t1_valid_idle", 32'(obs_valid), 32'd0);
        for (int i = 0; i < int'(N); i++) check($sformatf("t1_hs[%0d]", i), 32'(hs_cnt[i]), 32'd4);

        // Staggered acceptance of a single word.
        step(1'b1, 16'hA5A5, 3'b111, 3'b000, 1'b0);
        step(1'b0, '0, 3'b111, 3'b001, 1'b0);
        check("t2_v1", 32'(obs_valid), 32'b111); check("t2_r1", 32'(obs_ready), 32'd0);
        step(1'b0, '0, 3'b111, 3'b100, 1'b0);
        check("t2_v2", 32'(obs_valid), 32'b110); check("t2_r2", 32'(obs_ready), 32'd0);
        step(1'b0, '0, 3'b111, 3'b000, 1'b0);
        check("t2_v3", 32'(obs_valid), 32'b010); check("t2_r3", 32'(obs_ready), 32'd0);
        step(1'b0, '0, 3'b111, 3'b010, 1'b0);
        check("t2_v4", 32'(obs_valid), 32'b010); check("t2_r4", 32'(obs_ready), 32'd1);
        idle();
        check("t2_v5", 32'(obs_valid), 32'd0);
        exp_stall = STALL_EN ? 16'd3 : 16'd0;
        check("t2_stall", 32'(stall_count), 32'(exp_stall));

        // Masked branch with a permanently low ready.
        valid_seen = '0;
        step(1'b1, 16'h0010, 3'b101, 3'b101, 1'b0);
        check("t3_r0", 32'(obs_ready), 32'd1);
        step(1'b1, 16'h0011, 3'b101, 3'b101, 1'b0);
        check("t3_r1", 32'(obs_ready), 32'd1); check("t3_v1", 32'(obs_valid), 32'b101);
        step(1'b0, '0, 3'b101, 3'b101, 1'b0);
        check("t3_v2", 32'(obs_valid), 32'b101);
        idle();
        check("t3_v3", 32'(obs_valid), 32'd0);
        check("t3_branch1_never", 32'(valid_seen[1]), 32'd0);

        // Zero mask acts as a sink.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, DW'(16'h0020 + k), 3'b000, 3'b000, 1'b0);
            check("t4_ready", 32'(obs_ready), 32'd1);
            check("t4_valid", 32'(obs_valid), 32'd0);
        end
        idle();
        check("t4_valid_tail", 32'(obs_valid), 32'd0);
        check("t4_ready_tail", 32'(obs_ready), 32'd1);

        // Flush with one branch already served.
        step(1'b1, 16'h1234, 3'b111, 3'b000, 1'b0);
        step(1'b0, '0, 3'b111, 3'b001, 1'b0);
        check("t5_v0", 32'(obs_valid), 32'b111);
        step(1'b1, 16'h5678, 3'b111, 3'b111, 1'b1);
        check("t5_flush_ready", 32'(obs_ready), 32'd0);
        check("t5_flush_valid", 32'(obs_valid), 32'b110);
        step(1'b1, 16'h5678, 3'b111, 3'b111, 1'b0);
        check("t5_busy_after", 32'(obs_busy), 32'd0);
        check("t5_valid_after", 32'(obs_valid), 32'd0);
        check("t5_ready_after", 32'(obs_ready), 32'd1);
        step(1'b0, '0, 3'b111, 3'b111, 1'b0);
        check("t5_new_valid", 32'(obs_valid), 32'b111);
        idle();
        exp_stall = STALL_EN ? 16'd4 : 16'd0;
        check("t5_stall", 32'(stall_count), 32'(exp_stall));
        for (int i = 0; i < int'(N); i++)
            check($sformatf("sb_drained[%0d]", i), 32'(exp_q[i].size()), 32'd0);

        // Asynchronous reset between edges while a word is held.
        step(1'b1, 16'h9999, 3'b111, 3'b000, 1'b0);
        in_valid = 1'b0;
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_valid_pre", 32'(out_valid), 32'b111);
        #2;
        rst = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_stall", 32'(stall_count), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        clear_sb();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        check("t6_idle_valid", 32'(obs_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
